// File: rtl/player_motion_ctrl.sv
// Per-frame jump/gravity sequencer and post-hit blink timer for the player sprite.
// Every output is a register; motion and blink advance only on enabled frame ticks.
module player_motion_ctrl #(
  parameter int unsigned GroundY     = 360,
  parameter int unsigned JumpV0      = 12,
  parameter int unsigned Gravity     = 1,
  parameter int unsigned MaxFall     = 15,
  parameter int unsigned BlinkFrames = 60,
  parameter int unsigned BlinkPeriod = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick_i,
  input  logic       game_en_i,
  input  logic       jump_i,
  input  logic       hit_i,
  output logic [8:0] luc_loc_o,
  output logic       player_en_o,
  output logic       airborne_o,
  output logic       invuln_o
);
  localparam logic [1:0] S_GROUND = 2'd0;
  localparam logic [1:0] S_RISE   = 2'd1;
  localparam logic [1:0] S_FALL   = 2'd2;

  localparam int CW = $clog2(BlinkFrames + 1);
  localparam int PW = $clog2(BlinkPeriod + 1);

  localparam logic [8:0]    GY = 9'(GroundY);
  localparam logic [4:0]    V0 = 5'(JumpV0);
  localparam logic [4:0]    GR = 5'(Gravity);
  localparam logic [4:0]    MF = 5'(MaxFall);
  localparam logic [CW-1:0] BF = CW'(BlinkFrames);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [PW-1:0] BP = PW'(BlinkPeriod);
  localparam logic [PW-1:0] P1 = PW'(1);

  logic [1:0]    state, state_n;
  logic [8:0]    y_n;
  logic [4:0]    v, v_n;
  logic          jump_q, pend;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] phase, phase_n, phase_inc;
  logic          en_n;
  logic          rise, upd, jump_go;
  logic [9:0]    y_sum;
  logic [5:0]    v_inc;

  assign rise      = jump_i & ~jump_q;
  assign upd       = frame_tick_i & game_en_i;
  // a rise arriving on the tick cycle still launches the jump
  assign jump_go   = pend | rise;
  assign y_sum     = {1'b0, luc_loc_o} + {5'b0, v};
  assign v_inc     = {1'b0, v} + {1'b0, GR};
  assign phase_inc = phase + P1;

  always_comb begin
    state_n = state;
    y_n     = luc_loc_o;
    v_n     = v;
    if (upd) begin
      case (state)
        S_GROUND: if (jump_go) begin
          state_n = S_RISE;
          v_n     = V0;
        end
        S_RISE: if (luc_loc_o < {4'b0, v}) begin
          y_n     = '0;
          v_n     = '0;
          state_n = S_FALL;
        end else begin
          y_n = luc_loc_o - {4'b0, v};
          if (v <= GR) begin
            v_n     = '0;
            state_n = S_FALL;
          end else begin
            v_n = v - GR;
          end
        end
        S_FALL: if (y_sum >= {1'b0, GY}) begin
          y_n     = GY;
          v_n     = '0;
          state_n = S_GROUND;
        end else begin
          y_n = y_sum[8:0];
          v_n = (v_inc > {1'b0, MF}) ? MF : v_inc[4:0];
        end
        default: state_n = S_GROUND;
      endcase
    end
  end

  always_comb begin
    cnt_n   = cnt;
    phase_n = phase;
    en_n    = player_en_o;
    if (hit_i && game_en_i && cnt == '0) begin
      cnt_n   = BF;
      phase_n = '0;
      en_n    = 1'b0;
    end else if (upd && cnt != '0) begin
      cnt_n = cnt - C1;
      if (cnt == C1) begin
        phase_n = '0;
        en_n    = 1'b1;
      end else if (phase_inc == BP) begin
        phase_n = '0;
        en_n    = ~player_en_o;
      end else begin
        phase_n = phase_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_GROUND;
      luc_loc_o   <= GY;
      v           <= '0;
      jump_q      <= 1'b0;
      pend        <= 1'b0;
      cnt         <= '0;
      phase       <= '0;
      player_en_o <= 1'b1;
      airborne_o  <= 1'b0;
      invuln_o    <= 1'b0;
    end else begin
      state       <= state_n;
      luc_loc_o   <= y_n;
      v           <= v_n;
      jump_q      <= jump_i;
      pend        <= (!game_en_i || frame_tick_i) ? 1'b0 : (pend | rise);
      cnt         <= cnt_n;
      phase       <= phase_n;
      player_en_o <= en_n;
      airborne_o  <= (state_n != S_GROUND);
      invuln_o    <= (cnt_n != '0);
    end
  end
endmodule
